// File: rtl/axi_burst_master_if.sv
// AXI4 master-side channel bundle (AW/W/B/AR/R) used by axi_burst_master.
interface axi_burst_master_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) ();
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master with streaming write/read data ports.
// Optional watchdog: define AXI_BURST_MASTER_TIMEOUT_EN.
module axi_burst_master #(
    parameter int C_M_AXI_ID_WIDTH   = 4,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 64,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_SLAVE_BASE_ADDR = '0,
    parameter int C_MAX_BURST_LEN    = 16,
    parameter int C_TIMEOUT_BITS     = 10
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,

    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [7:0]                      req_len,
    input  logic [2:0]                      req_size,

    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   wr_data,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] wr_strb,

    output logic                            rd_valid,
    input  logic                            rd_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rd_data,
    output logic                            rd_last,

    output logic                            done_valid,
    output logic                            done_err,
    output logic                            busy,

    axi_burst_master_if.master              m_axi
);
    localparam int AW       = C_M_AXI_ADDR_WIDTH;
    localparam int IW       = C_M_AXI_ID_WIDTH;
    localparam int MAX_SIZE = $clog2(C_M_AXI_DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_AW, S_W, S_B, S_AR, S_R, S_DONE
    } state_t;

    state_t          state_reg;
    logic [AW-1:0]   addr_reg;
    logic [7:0]      len_reg;
    logic [2:0]      size_reg;
    logic            write_reg;
    logic [IW-1:0]   id_reg;
    logic [IW-1:0]   issued_id_reg;
    logic [7:0]      beat_reg;
    logic            err_reg;
    logic            req_ready_reg;
    logic            done_valid_reg;
    logic            done_err_reg;
    logic            busy_reg;
    logic            awvalid_reg;
    logic            arvalid_reg;
    logic            bready_reg;

    logic [AW-1:0]   burst_bytes;
    logic [AW-1:0]   last_byte;
    logic            chk_err;
    logic            at_last;
    logic            r_beat_err;
    logic            tmo_hit;

    // Request legality: beat count, beat size vs bus width, and 4KB crossing.
    assign burst_bytes = AW'({1'b0, len_reg} + 9'd1) << size_reg;
    assign last_byte   = addr_reg + burst_bytes - AW'(1);
    assign chk_err     = (int'(len_reg) >= C_MAX_BURST_LEN)
                      || (int'(size_reg) > MAX_SIZE)
                      || (last_byte[AW-1:12] != addr_reg[AW-1:12]);

    assign at_last    = (beat_reg == len_reg);
    assign r_beat_err = m_axi.rresp[1] || (m_axi.rid != issued_id_reg)
                     || (m_axi.rlast != at_last);

`ifdef AXI_BURST_MASTER_TIMEOUT_EN
    logic [C_TIMEOUT_BITS-1:0] tmo_reg;
    logic                      tmo_active;
    logic                      any_hs;

    assign tmo_active = (state_reg == S_AW) || (state_reg == S_W) || (state_reg == S_B)
                     || (state_reg == S_AR) || (state_reg == S_R);
    assign any_hs = (m_axi.awvalid && m_axi.awready) || (m_axi.wvalid && m_axi.wready)
                 || (m_axi.bvalid && m_axi.bready)   || (m_axi.arvalid && m_axi.arready)
                 || (m_axi.rvalid && m_axi.rready);
    assign tmo_hit = tmo_active && (&tmo_reg) && !any_hs;

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            tmo_reg <= '0;
        end else if (!tmo_active || any_hs) begin
            tmo_reg <= '0;
        end else if (!(&tmo_reg)) begin
            tmo_reg <= tmo_reg + 1'b1;
        end
    end
`else
    localparam int unused_timeout_bits = C_TIMEOUT_BITS;
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_reg      <= S_IDLE;
            addr_reg       <= '0;
            len_reg        <= '0;
            size_reg       <= '0;
            write_reg      <= 1'b0;
            id_reg         <= '0;
            issued_id_reg  <= '0;
            beat_reg       <= '0;
            err_reg        <= 1'b0;
            req_ready_reg  <= 1'b0;
            done_valid_reg <= 1'b0;
            done_err_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            awvalid_reg    <= 1'b0;
            arvalid_reg    <= 1'b0;
            bready_reg     <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (req_valid && req_ready_reg) begin
                        req_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        addr_reg      <= req_addr;
                        len_reg       <= req_len;
                        size_reg      <= req_size;
                        write_reg     <= req_write;
                        state_reg     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (chk_err) begin
                        done_valid_reg <= 1'b1;
                        done_err_reg   <= 1'b1;
                        state_reg      <= S_DONE;
                    end else if (write_reg) begin
                        awvalid_reg <= 1'b1;
                        state_reg   <= S_AW;
                    end else begin
                        arvalid_reg <= 1'b1;
                        state_reg   <= S_AR;
                    end
                end
                S_AW: begin
                    if (tmo_hit) begin
                        awvalid_reg    <= 1'b0;
                        done_valid_reg <= 1'b1;
                        done_err_reg   <= 1'b1;
                        state_reg      <= S_DONE;
                    end else if (m_axi.awready) begin
                        awvalid_reg   <= 1'b0;
                        issued_id_reg <= id_reg;
                        id_reg        <= id_reg + 1'b1;
                        beat_reg      <= '0;
                        state_reg     <= S_W;
                    end
                end
                S_W: begin
                    if (tmo_hit) begin
                        done_valid_reg <= 1'b1;
                        done_err_reg   <= 1'b1;
                        state_reg      <= S_DONE;
                    end else if (wr_valid && m_axi.wready) begin
                        beat_reg <= beat_reg + 1'b1;
                        if (at_last) begin
                            bready_reg <= 1'b1;
                            state_reg  <= S_B;
                        end
                    end
                end
                S_B: begin
                    if (tmo_hit) begin
                        bready_reg     <= 1'b0;
                        done_valid_reg <= 1'b1;
                        done_err_reg   <= 1'b1;
                        state_reg      <= S_DONE;
                    end else if (m_axi.bvalid) begin
                        bready_reg     <= 1'b0;
                        done_valid_reg <= 1'b1;
                        done_err_reg   <= m_axi.bresp[1] || (m_axi.bid != issued_id_reg);
                        state_reg      <= S_DONE;
                    end
                end
                S_AR: begin
                    if (tmo_hit) begin
                        arvalid_reg    <= 1'b0;
                        done_valid_reg <= 1'b1;
                        done_err_reg   <= 1'b1;
                        state_reg      <= S_DONE;
                    end else if (m_axi.arready) begin
                        arvalid_reg   <= 1'b0;
                        issued_id_reg <= id_reg;
                        id_reg        <= id_reg + 1'b1;
                        beat_reg      <= '0;
                        err_reg       <= 1'b0;
                        state_reg     <= S_R;
                    end
                end
                S_R: begin
                    if (tmo_hit) begin
                        done_valid_reg <= 1'b1;
                        done_err_reg   <= 1'b1;
                        state_reg      <= S_DONE;
                    end else if (m_axi.rvalid && rd_ready) begin
                        // The slave's RLAST ends the burst; a count mismatch only flags an error.
                        beat_reg <= beat_reg + 1'b1;
                        err_reg  <= err_reg || r_beat_err;
                        if (m_axi.rlast) begin
                            done_valid_reg <= 1'b1;
                            done_err_reg   <= err_reg || r_beat_err;
                            state_reg      <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_valid_reg <= 1'b0;
                    done_err_reg   <= 1'b0;
                    busy_reg       <= 1'b0;
                    req_ready_reg  <= 1'b1;
                    state_reg      <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_reg;
    assign done_valid = done_valid_reg;
    assign done_err   = done_err_reg;
    assign busy       = busy_reg;

    assign m_axi.awid    = id_reg;
    assign m_axi.awaddr  = addr_reg + C_M_TARGET_SLAVE_BASE_ADDR;
    assign m_axi.awlen   = len_reg;
    assign m_axi.awsize  = size_reg;
    assign m_axi.awburst = 2'b01;
    assign m_axi.awvalid = awvalid_reg;

    assign m_axi.arid    = id_reg;
    assign m_axi.araddr  = addr_reg + C_M_TARGET_SLAVE_BASE_ADDR;
    assign m_axi.arlen   = len_reg;
    assign m_axi.arsize  = size_reg;
    assign m_axi.arburst = 2'b01;
    assign m_axi.arvalid = arvalid_reg;

    // Data channels are steered straight through, gated only by state.
    assign m_axi.wvalid = (state_reg == S_W) && wr_valid;
    assign m_axi.wdata  = wr_data;
    assign m_axi.wstrb  = wr_strb;
    assign m_axi.wlast  = (state_reg == S_W) && at_last;
    assign wr_ready     = (state_reg == S_W) && m_axi.wready;

    assign m_axi.bready = bready_reg;

    assign m_axi.rready = (state_reg == S_R) && rd_ready;
    assign rd_valid     = (state_reg == S_R) && m_axi.rvalid;
    assign rd_data      = m_axi.rdata;
    assign rd_last      = m_axi.rlast;

    logic unused_resp_bits;
    assign unused_resp_bits = ^{m_axi.rresp[0], m_axi.bresp[0]};
endmodule

// File: tb/tb_axi_burst_master.sv
// Randomized directed bench for axi_burst_master with a transaction-level slave/consumer model.
module tb_axi_burst_master;
    localparam int IW   = 4;
    localparam int AW   = 32;
    localparam int DW   = 64;
    localparam int MAXB = 16;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_write = 1'b0;
    logic [AW-1:0]   req_addr  = '0;
    logic [7:0]      req_len   = '0;
    logic [2:0]      req_size  = '0;
    logic            wr_valid  = 1'b0;
    logic            wr_ready;
    logic [DW-1:0]   wr_data   = '0;
    logic [DW/8-1:0] wr_strb   = '0;
    logic            rd_valid;
    logic            rd_ready  = 1'b0;
    logic [DW-1:0]   rd_data;
    logic            rd_last;
    logic            done_valid;
    logic            done_err;
    logic            busy;

    axi_burst_master_if #(.ID_W(IW), .ADDR_W(AW), .DATA_W(DW)) axi ();

    axi_burst_master #(
        .C_M_AXI_ID_WIDTH(IW),
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW),
        .C_M_TARGET_SLAVE_BASE_ADDR(BASE),
        .C_MAX_BURST_LEN(MAXB),
        .C_TIMEOUT_BITS(4)
    ) dut (
        .M_AXI_ACLK(clk),
        .M_AXI_ARESET(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_len(req_len),
        .req_size(req_size),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_data(wr_data),
        .wr_strb(wr_strb),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .rd_data(rd_data),
        .rd_last(rd_last),
        .done_valid(done_valid),
        .done_err(done_err),
        .busy(busy),
        .m_axi(axi.master)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int id_model = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        req_valid   = 1'b0;
        wr_valid    = 1'b0;
        rd_ready    = 1'b0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bid     = '0;
        axi.bresp   = 2'b00;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rid     = '0;
        axi.rdata   = '0;
        axi.rresp   = 2'b00;
        axi.rlast   = 1'b0;
    endtask

    // One request end to end; the slave and data consumer are modelled per cycle here.
    task automatic run_txn(input string tag, input bit wr, input logic [31:0] addr,
                           input int len, input int size, input logic [63:0] seed,
                           input int bad_beat, input bit bad_id, input int stall,
                           input int abort_at, input bit hang);
        longint        span;
        bit            chk_err, exp_err, addr_done, w_done, b_done;
        bit            done_seen, got_err, proto_bad, r_hold, aborted;
        int            w_cnt, r_sent, r_got, cyc, exp_beats;
        logic [IW-1:0] issued;

        span    = longint'(addr % 32'd4096) + longint'(len + 1) * (longint'(1) << size);
        chk_err = (len >= MAXB) || (size > 3) || (span > 4096);
        exp_err = chk_err || hang || (wr ? bad_id : (bad_beat >= 0 && bad_beat <= len));
        exp_beats = (chk_err || hang) ? 0 : len + 1;
        addr_done = 0; w_done = 0; b_done = 0; done_seen = 0; got_err = 0;
        proto_bad = 0; r_hold = 0; aborted = 0;
        w_cnt = 0; r_sent = 0; r_got = 0; issued = '0;

        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_len   = 8'(len);
        req_size  = 3'(size);
        cyc = 0;
        while (req_ready !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " req_ready"}, 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;

        for (cyc = 0; cyc < 400 && !done_seen && !aborted; cyc++) begin
            axi.awready = !hang && ($urandom_range(99) >= stall);
            axi.arready = !hang && ($urandom_range(99) >= stall);
            axi.wready  = ($urandom_range(99) >= stall);
            wr_valid    = wr && !w_done && ($urandom_range(99) >= stall);
            wr_data     = seed + 64'(w_cnt);
            wr_strb     = 8'($urandom);
            if (!r_hold)
                axi.rvalid = !wr && addr_done && (r_sent <= len) && ($urandom_range(99) >= stall);
            axi.rdata   = seed + 64'(r_sent);
            axi.rlast   = (r_sent == len);
            axi.rresp   = (r_sent == bad_beat) ? 2'b10 : 2'b00;
            axi.rid     = issued;
            axi.bvalid  = w_done && !b_done && ($urandom_range(99) >= stall);
            axi.bid     = issued ^ IW'(bad_id);
            axi.bresp   = 2'b00;
            rd_ready    = ($urandom_range(99) >= stall);
            #1;

            if (axi.wvalid && !addr_done) proto_bad = 1;
            if ((wr && axi.arvalid) || (!wr && axi.awvalid)) proto_bad = 1;
            if (chk_err && (axi.awvalid || axi.arvalid)) proto_bad = 1;
            if (done_valid === 1'b1) begin
                done_seen = 1;
                got_err   = done_err;
            end
            if (axi.awvalid && axi.awready) begin
                check({tag, " awaddr"},  64'(axi.awaddr),  64'(addr + BASE));
                check({tag, " awlen"},   64'(axi.awlen),   64'(len));
                check({tag, " awsize"},  64'(axi.awsize),  64'(size));
                check({tag, " awburst"}, 64'(axi.awburst), 64'd1);
                check({tag, " awid"},    64'(axi.awid),    64'(id_model));
                issued    = IW'(id_model);
                id_model  = (id_model + 1) % 16;
                addr_done = 1;
            end
            if (axi.arvalid && axi.arready) begin
                check({tag, " araddr"},  64'(axi.araddr),  64'(addr + BASE));
                check({tag, " arlen"},   64'(axi.arlen),   64'(len));
                check({tag, " arsize"},  64'(axi.arsize),  64'(size));
                check({tag, " arburst"}, 64'(axi.arburst), 64'd1);
                check({tag, " arid"},    64'(axi.arid),    64'(id_model));
                issued    = IW'(id_model);
                id_model  = (id_model + 1) % 16;
                addr_done = 1;
            end
            if (axi.wvalid && axi.wready) begin
                check({tag, " wlast"}, 64'(axi.wlast), 64'(w_cnt == len));
                check({tag, " wdata"}, axi.wdata, seed + 64'(w_cnt));
                w_cnt++;
                if (w_cnt == len + 1) w_done = 1;
            end
            if (axi.rvalid && axi.rready) r_sent++;
            r_hold = axi.rvalid && !axi.rready;
            if (rd_valid && rd_ready) begin
                check({tag, " rd_data"}, rd_data, seed + 64'(r_got));
                check({tag, " rd_last"}, 64'(rd_last), 64'(r_got == len));
                r_got++;
            end
            if (axi.bvalid && axi.bready) b_done = 1;

            if (abort_at >= 0 && w_cnt == abort_at) begin
                @(posedge clk);
                #2;
                rst = 1'b1;
                #1;
                check({tag, " abort awvalid"}, 64'(axi.awvalid), 64'd0);
                check({tag, " abort wvalid"},  64'(axi.wvalid),  64'd0);
                check({tag, " abort busy"},    64'(busy),        64'd0);
                aborted = 1;
                @(negedge clk);
                rst = 1'b0;
                id_model = 0;
            end else if (!done_seen) begin
                @(negedge clk);
            end
        end

        clear_inputs();
        if (aborted) return;
        check({tag, " done_seen"}, 64'(done_seen), 64'd1);
        check({tag, " done_err"},  64'(got_err),   64'(exp_err));
        check({tag, " beats"},     64'(wr ? w_cnt : r_got), 64'(exp_beats));
        check({tag, " addr_phase"}, 64'(addr_done), 64'(!(chk_err || hang)));
        check({tag, " ordering"},  64'(proto_bad), 64'd0);
        if (hang) check({tag, " valids_dropped"}, 64'(axi.awvalid | axi.arvalid), 64'd0);
        @(negedge clk);
        #1;
        check({tag, " done_pulse"}, 64'(done_valid), 64'd0);
        check({tag, " idle_busy"},  64'(busy),       64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  len, bb;
        bit  wr;
        clear_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy",       64'(busy),        64'd0);
        check("reset done_valid", 64'(done_valid),  64'd0);
        check("reset req_ready",  64'(req_ready),   64'd0);
        check("reset awvalid",    64'(axi.awvalid), 64'd0);
        check("reset arvalid",    64'(axi.arvalid), 64'd0);
        check("reset bready",     64'(axi.bready),  64'd0);
        check("reset wvalid",     64'(axi.wvalid),  64'd0);
        check("reset rd_valid",   64'(rd_valid),    64'd0);
        rst = 1'b0;

        run_txn("rd_basic",   0, 32'h0000_1000, 3, 3, 64'hA, -1, 0, 0, -1, 0);
        run_txn("wr_stall",   1, 32'h0000_2040, 7, 3, 64'($urandom), -1, 0, 40, -1, 0);
        run_txn("wr_len0",    1, 32'h0000_0100, 0, 2, 64'($urandom), -1, 0, 20, -1, 0);
        run_txn("cross_4k",   1, 32'h0000_0FF8, 1, 3, 64'h0, -1, 0, 0, -1, 0);
        run_txn("len_max",    0, 32'h0000_0000, MAXB, 0, 64'h0, -1, 0, 0, -1, 0);
        run_txn("size_big",   0, 32'h0000_0000, 0, 4, 64'h0, -1, 0, 0, -1, 0);
        run_txn("rd_slverr",  0, 32'h0000_3000, 3, 3, 64'h100, 2, 0, 20, -1, 0);
        run_txn("wr_bid_bad", 1, 32'h0000_3100, 2, 3, 64'h200, -1, 1, 20, -1, 0);
        run_txn("rd_edge_4k", 0, 32'h0000_0FF0, 1, 3, 64'h300, -1, 0, 10, -1, 0);

        for (int k = 0; k < 12; k++) begin
            wr  = 1'($urandom_range(1));
            len = $urandom_range(17);
            bb  = ($urandom_range(3) == 0) ? $urandom_range(len) : -1;
            run_txn($sformatf("rand%0d", k), wr, 32'($urandom_range(16383)), len,
                    $urandom_range(4), {$urandom, $urandom}, bb,
                    1'($urandom_range(3) == 0), $urandom_range(50), -1, 0);
        end

        run_txn("wr_abort",  1, 32'h0000_4000, 7, 3, 64'h400, -1, 0, 30, 3, 0);
        run_txn("post_reset", 0, 32'h0000_5000, 1, 3, 64'h500, -1, 0, 0, -1, 0);

`ifdef AXI_BURST_MASTER_TIMEOUT_EN
        run_txn("ar_timeout", 0, 32'h0000_6000, 0, 3, 64'h600, -1, 0, 0, -1, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- Parametrised successor to the single-beat AXI4 full master; serves CPU/cache requests as real AXI4 INCR bursts of 1..C_MAX_BURST_LEN beats.
- Provides a streaming write-data port, a streaming read-data port and a completion/response port.
- One outstanding transaction; sits between the cache/LSU and the AXI interconnect.

Parameters:
- C_M_TARGET_SLAVE_BASE_ADDR, 32'h00000000, added to the request address on AWADDR/ARADDR
- C_M_AXI_ID_WIDTH, 4, AXI ID width
- C_M_AXI_ADDR_WIDTH, 32, address width
- C_M_AXI_DATA_WIDTH, 64, data width (32/64/128)
- C_MAX_BURST_LEN, 16, maximum beats per request (1..256)
- C_TIMEOUT_BITS, 10, watchdog width (used only with the optional feature)

Ports:
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESET  in  1  asynchronous reset, active-high
- req_valid/req_ready  in/out  1  request handshake
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR  byte address
- req_len  in  8  beats-1
- req_size  in  3  AXI size code
- wr_valid/wr_ready  in/out  1  write-data handshake
- wr_data  in  DATA  write data
- wr_strb  in  DATA/8  write strobes
- rd_valid/rd_ready  out/in  1  read-data handshake
- rd_data  out  DATA  read data
- rd_last  out  1  last beat
- done_valid  out  1  one-cycle completion pulse
- done_err  out  1  error flag, valid with done_valid
- busy  out  1  state != IDLE
- M_AXI_AW*/W*/B*/AR*/R*  standard AXI4 master channel signals: AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, AWREADY, WDATA, WSTRB, WLAST, WVALID, WREADY, BID, BRESP, BVALID, BREADY, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, ARREADY, RID, RDATA, RRESP, RLAST, RVALID, RREADY

Behaviour:
- States: IDLE, CHECK, AW, W, B, AR, R, DONE.
- Reset values: all VALID/READY/done/busy outputs 0; state IDLE; ID counter 0; beat counter 0. Reset asserted mid-burst abandons the transaction immediately and drops all valids.
- IDLE: req_ready=1. On req_valid, latch addr, len, size and write; go to CHECK.
- CHECK (1 cycle): err if any of
  - req_len >= C_MAX_BURST_LEN
  - req_size > log2(DATA/8)
  - the burst crosses 4KB, i.e. addr[ADDR-1:12] != (addr + ((len+1)<<size) - 1)[ADDR-1:12]
- CHECK outcome: on err go to DONE with done_err=1 and no AXI traffic; otherwise go to AW or AR.
- AW/AR: VALID held with stable fields until READY.
  - AxLEN=len, AxSIZE=size, AxBURST=2'b01, AxID = ID counter.
  - ID counter increments (wrapping) on each address handshake.
- W:
  - WVALID=wr_valid, wr_ready=WREADY, data and strobes pass through combinationally.
  - Beat counter increments on each handshake.
  - WLAST=1 exactly when counter==len; also correct for len=0.
  - Handshake with WLAST goes to B.
- B: BREADY=1. On BVALID, done_err = BRESP[1] | (BID != issued ID); go to DONE.
- R:
  - RREADY=rd_ready, rd_valid=RVALID, rd_data=RDATA, rd_last=RLAST.
  - Sticky err is set by any RRESP[1] or RID mismatch.
  - Beat counter checks RLAST: RLAST early or missing at counter==len sets err. The transaction always ends on the RLAST handshake.
  - Then go to DONE.
- DONE: done_valid=1 for one cycle, then IDLE. Min latency req accept to done_valid (1-beat, zero-wait slave): 5 cycles.
- W is never issued before the AW handshake, and AR is never issued during a write.

Optional Feature:
- Macro AXI_BURST_MASTER_TIMEOUT_EN.
- Defined:
  - A C_TIMEOUT_BITS counter runs in AW/W/B/AR/R and clears on any handshake.
  - On saturation, all valids drop and the block goes to DONE with done_err=1.
- Undefined: no counter; the block waits indefinitely.

Test Plan:
- Read: addr 0x1000, len=3, size=3, zero-wait slave with RDATA 0xA..0xD -> ARLEN=3, ARBURST=01, four rd beats, rd_last on the 4th, done_err=0.
- Write: len=7 with random WREADY stalls -> exactly 8 W beats, WLAST only on the 8th, BRESP=OKAY -> done_err=0.
- Boundary: addr 0x0FF8, len=1, size=3 -> err (crosses 4KB), no AWVALID. Request with len=C_MAX_BURST_LEN -> err.
- Error response: RRESP=SLVERR on beat 2 of 4 -> all 4 beats delivered, done_err=1. BID mismatch on a write -> done_err=1.
- Reset mid-W burst (after beat 3) -> WVALID/AWVALID=0 immediately, state IDLE, next request's ID=0.
- TIMEOUT_EN with C_TIMEOUT_BITS=4 and ARREADY held low -> done_err=1 after 16 cycles, ARVALID drops.
